// File: rtl/xor_bit_packer_pkg.sv
// Shared types and constants for the XOR bit packer:
// assembler FSM state encoding and output FIFO depth.
package xor_bit_packer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/xor_bit_packer_fifo.sv
// pack_fifo2: 2-entry FIFO for packed words, head at e0.
// Ports: clk, resetb, push/push_data in, rdy in, head/vld out, drop out.
module pack_fifo2
  import xor_bit_packer_pkg::*;
#(
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          rdy,
  output logic [DW-1:0] head,
  output logic          vld,
  output logic          drop
);

  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [1:0]    n;
  logic          pop;
  logic          full;

  assign vld  = (n != 2'd0);
  assign pop  = vld && rdy;
  assign full = (n == 2'(FIFO_DEPTH));
  // Full with a pop in the same edge still accepts the push.
  assign drop = push && full && !pop;
  assign head = e0;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      e0 <= '0;
      e1 <= '0;
      n  <= 2'd0;
    end else begin
      unique case (n)
        2'd0: begin
          if (push) begin
            e0 <= push_data;
            n  <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && push) begin
            e0 <= push_data;
          end else if (pop) begin
            n <= 2'd0;
          end else if (push) begin
            e1 <= push_data;
            n  <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            e0 <= e1;
            if (push) e1 <= push_data;
            else      n  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/xor_bit_packer.sv
// Packs serial bits LSB-first into WIDTH-bit words with count and parity.
// Ports: clk, resetb, bit_in/bit_vld/flush in; out_* word + handshake; ovf.
module xor_bit_packer
  import xor_bit_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_cnt,
  output logic             out_par,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int DW = WIDTH + CW + 1;

  pack_state_t      state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;

  logic [WIDTH-1:0] nxt_sreg;
  logic [CW-1:0]    nxt_cnt;
  logic             last;
  logic             push;
  logic [DW-1:0]    push_data;
  logic [DW-1:0]    head;
  logic             drop;

  // Bits above cnt are always zero, so OR-in gives zero fill.
  assign nxt_sreg = bit_vld
                  ? (sreg | (WIDTH'(bit_in) << cnt))
                  : sreg;
  assign nxt_cnt  = cnt + CW'(bit_vld);
  assign last     = bit_vld && (cnt == CW'(WIDTH - 1));
  assign push     = last
                 || (flush && ((state == FILL) || bit_vld));
  assign push_data = {^nxt_sreg, nxt_cnt, nxt_sreg};

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (push) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (bit_vld) begin
      state <= FILL;
      cnt   <= nxt_cnt;
      sreg  <= nxt_sreg;
    end
  end

  pack_fifo2 #(
    .DW(DW)
  ) u_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .push      (push),
    .push_data (push_data),
    .rdy       (out_rdy),
    .head      (head),
    .vld       (out_vld),
    .drop      (drop)
  );

  assign out_data = head[WIDTH-1:0];
  assign out_cnt  = head[WIDTH+CW-1:WIDTH];
  assign out_par  = head[DW-1];

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)      ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule
